instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL provide parameter: XLEN, 32, datapath/PC width.
REQ-002 SHALL provide parameter: BHT_ENTRIES, 16, branch history table depth (power of two).
REQ-003 SHALL provide parameter: RESET_PC, 32'h0000_0000, PC value after reset.
REQ-004 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port: stall  input  1  hazard-unit request to hold PC.
REQ-007 SHALL provide port: ex_mispredict  input  1  EX-stage redirect request.
REQ-008 SHALL provide port: ex_redirect_pc  input  XLEN  correct next PC from EX.
REQ-009 SHALL provide port: ex_branch_valid  input  1  conditional branch resolved in EX this cycle.
REQ-010 SHALL provide port: ex_branch_pc  input  XLEN  PC of resolved branch.
REQ-011 SHALL provide port: ex_branch_taken  input  1  actual outcome of resolved branch.
REQ-012 SHALL provide port: imem_addr  output  XLEN  instruction memory address (equals PC).
REQ-013 SHALL provide port: imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-014 SHALL provide port: IF_pc  output  XLEN  current PC to IF/ID register.
REQ-015 SHALL provide port: IF_pc_plus_4  output  XLEN  PC+4 to IF/ID register.
REQ-016 SHALL provide port: IF_instruction  output  32  fetched word (imem_rdata passthrough).
REQ-017 SHALL provide port: IF_branch_estimation  output  1  prediction taken for fetched instruction.

Function
REQ-018 SHALL hold PC in one XLEN register; imem_addr, IF_pc = PC; IF_pc_plus_4 = PC+4 modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
REQ-019 SHALL decode fetched opcode combinationally: 1101111 (JAL) -> estimation 1, target = PC + J-imm; 1100011 (branch) -> estimation = BHT[PC[log2(BHT_ENTRIES)+1:2]] MSB, target = PC + B-imm (sign-extended); all others incl. JALR -> estimation 0.
REQ-020 SHALL select next PC with priority: ex_mispredict -> {ex_redirect_pc[XLEN-1:2],2'b00}; else stall -> PC; else estimation -> target; else PC+4.
REQ-021 SHALL maintain BHT of 2-bit saturating counters (00 SNT, 01 WNT, 10 WT, 11 ST), indexed by ex_branch_pc[log2(BHT_ENTRIES)+1:2] on update.
REQ-022 SHALL on ex_branch_valid increment counter if taken (saturate at 11), else decrement (saturate at 00); update independent of stall and ex_mispredict.
REQ-023 SHALL, when update and prediction hit same index in one cycle, predict from pre-update value; new value visible next cycle.
REQ-024 SHALL keep IF_* outputs reflecting current PC during an ex_mispredict cycle (downstream flush discards them); PC takes redirect on next edge.
REQ-025 SHALL have zero-cycle fetch latency: IF_* valid in same cycle as PC.

Reset
REQ-026 SHALL on reset asserted (asynchronously, including mid-operation) set PC = RESET_PC and all BHT counters = 01 (weakly not-taken).
REQ-027 SHALL after reset release output IF_pc = RESET_PC, IF_pc_plus_4 = RESET_PC+4, IF_branch_estimation 0 for non-JAL, IF_instruction = imem_rdata.
REQ-028 SHALL ignore stall, ex_mispredict, ex_branch_valid while reset asserted.

Structure
REQ-029 SHALL place opcode constants (OPCODE_JAL, OPCODE_BRANCH) and counter encodings (SNT/WNT/WT/ST) in shared package rv32i_pkg.
REQ-030 SHALL implement BHT as sub-module branch_history_table (read index, update index/valid/taken, one 2-bit read port).

Verification
REQ-031 SHALL verify reset: assert reset 30 ns, release -> IF_pc 0x0, IF_pc_plus_4 0x4; reset mid-run at PC 0x40 -> PC 0x0 immediately.
REQ-032 SHALL verify sequential fetch: imem_rdata 0x2BC00093 (ADDI) each cycle -> PC 0x0,0x4,0x8; stall=1 one cycle -> PC held at 0x8 then 0xC.
REQ-033 SHALL verify JAL: at PC 0x10, imem_rdata 0x0100006F (jal x0,+16) -> IF_branch_estimation 1, next PC 0x20.
REQ-034 SHALL verify BHT training: branch 0x00000463 (beq x0,x0,+8) at PC 0x0 -> estimation 0, next 0x4; two ex_branch_valid taken updates for PC 0x0 -> next fetch at 0x0 estimation 1, next PC 0x8; four not-taken updates -> counter saturates 00.
REQ-035 SHALL verify priority: ex_mispredict=1, ex_redirect_pc 0x1236, stall=1, JAL fetched same cycle -> next PC 0x1234.
REQ-036 SHALL verify wrap: PC forced via redirect to 0xFFFF_FFFC, ADDI fetched -> IF_pc_plus_4 0x0, next PC 0x0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I constants used by the fetch stage:
//   - major opcodes that the fetch-stage predictor recognises (JAL, BRANCH)
//   - 2-bit branch-history counter encodings
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    // Saturating branch-history counter; MSB set means "predict taken".
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } bht_ctr_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Instruction-memory bus between the fetch unit and the instruction memory.
//   imem_addr  : fetch address (the current PC), driven by the fetch unit
//   imem_rdata : instruction word, combinational read of imem_addr
// Modports:
//   master : fetch unit side (drives address, receives data)
//   slave  : memory side (receives address, drives data)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit_bht.sv
// -----------------------------------------------------------------------------
// branch_history_table
// Table of 2-bit saturating counters used for conditional-branch prediction.
// One combinational read port (prediction) and one synchronous update port
// (branch resolution). A read and an update to the same entry in one cycle
// returns the pre-update value; the new value is visible the next cycle.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset, all counters -> WNT
//   rd_idx_i     : prediction read index
//   rd_ctr_o     : counter value at rd_idx_i
//   upd_valid_i  : a conditional branch resolved this cycle
//   upd_idx_i    : index of the resolved branch
//   upd_taken_i  : actual outcome of the resolved branch
// -----------------------------------------------------------------------------
module branch_history_table
    import rv32i_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_ctr_e ctr_q [ENTRIES];
    bht_ctr_e ctr_d;

    // Saturating step: move one state towards taken or not-taken.
    function automatic bht_ctr_e ctr_next(input bht_ctr_e cur, input logic taken);
        bht_ctr_e nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

    assign ctr_d    = ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_valid_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// IF stage: holds the PC, fetches from instruction memory with zero-cycle
// latency, predicts JAL (always taken) and conditional branches (BHT MSB),
// and selects the next PC.
// Ports:
//   clk, reset          : clock / asynchronous active-high reset
//   stall               : hold PC this cycle
//   ex_mispredict       : redirect PC to ex_redirect_pc (word aligned)
//   ex_redirect_pc      : correct next PC from EX
//   ex_branch_valid     : conditional branch resolved in EX (BHT update)
//   ex_branch_pc        : PC of the resolved branch
//   ex_branch_taken     : actual outcome of the resolved branch
//   imem                : instruction-memory bus (master)
//   IF_pc               : current PC
//   IF_pc_plus_4        : PC + 4 (wraps modulo 2^XLEN)
//   IF_instruction      : fetched instruction word
//   IF_branch_estimation: fetched instruction predicted taken
// -----------------------------------------------------------------------------
module instruction_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              BHT_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                ex_mispredict,
    input  logic [XLEN-1:0]     ex_redirect_pc,
    input  logic                ex_branch_valid,
    input  logic [XLEN-1:0]     ex_branch_pc,
    input  logic                ex_branch_taken,
    instruction_fetch_unit_if.master imem,
    output logic [XLEN-1:0]     IF_pc,
    output logic [XLEN-1:0]     IF_pc_plus_4,
    output logic [31:0]         IF_instruction,
    output logic                IF_branch_estimation
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] j_imm, b_imm, target;
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [1:0]      bht_ctr;
    logic            predict_taken;

    assign instr     = imem.imem_rdata;
    assign opcode    = instr[6:0];
    assign pc_plus_4 = pc_q + XLEN'(4);

    // Immediates are sign-extended from instr[31] to the full datapath width.
    assign j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (pc_q[IDX_W+1:2]),
        .rd_ctr_o    (bht_ctr),
        .upd_valid_i (ex_branch_valid),
        .upd_idx_i   (ex_branch_pc[IDX_W+1:2]),
        .upd_taken_i (ex_branch_taken)
    );

    // Word-offset bits of the redirect/branch addresses play no role here.
    logic unused_bits;
    assign unused_bits = ^{ex_redirect_pc[1:0], ex_branch_pc[XLEN-1:IDX_W+2], ex_branch_pc[1:0]};

    // Predecode: JAL always taken; conditional branch follows the counter MSB.
    // JALR needs a register value, so it is never predicted here.
    always_comb begin
        predict_taken = 1'b0;
        target        = pc_plus_4;
        case (opcode)
            OPCODE_JAL: begin
                predict_taken = 1'b1;
                target        = pc_q + j_imm;
            end
            OPCODE_BRANCH: begin
                predict_taken = bht_ctr[1];
                target        = pc_q + b_imm;
            end
            default: ;
        endcase
    end

    // Next PC priority: EX redirect, then stall, then prediction, then PC+4.
    always_comb begin
        pc_d = pc_plus_4;
        if (ex_mispredict) begin
            pc_d = {ex_redirect_pc[XLEN-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (predict_taken) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem.imem_addr       = pc_q;
    assign IF_pc                = pc_q;
    assign IF_pc_plus_4         = pc_plus_4;
    assign IF_instruction       = instr;
    assign IF_branch_estimation = predict_taken;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed scenarios plus a randomized run checked against a behavioural
// model of the fetch unit (PC and an integer array of branch counters).
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;
    import rv32i_pkg::*;

    localparam int XLEN = 32;
    localparam int NBHT = 16;
    localparam logic [31:0] ADDI  = 32'h2BC0_0093;
    localparam logic [31:0] JAL16 = 32'h0100_006F;
    localparam logic [31:0] BEQ8  = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0, ex_mispredict = 1'b0, ex_branch_valid = 1'b0, ex_branch_taken = 1'b0;
    logic [31:0] ex_redirect_pc = '0, ex_branch_pc = '0;
    logic [31:0] IF_pc, IF_pc_plus_4, IF_instruction;
    logic        IF_branch_estimation;

    instruction_fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

    instruction_fetch_unit #(.XLEN(XLEN), .BHT_ENTRIES(NBHT), .RESET_PC(32'h0)) dut (
        .clk                  (clk),
        .reset                (reset),
        .stall                (stall),
        .ex_mispredict        (ex_mispredict),
        .ex_redirect_pc       (ex_redirect_pc),
        .ex_branch_valid      (ex_branch_valid),
        .ex_branch_pc         (ex_branch_pc),
        .ex_branch_taken      (ex_branch_taken),
        .imem                 (imem_bus),
        .IF_pc                (IF_pc),
        .IF_pc_plus_4         (IF_pc_plus_4),
        .IF_instruction       (IF_instruction),
        .IF_branch_estimation (IF_branch_estimation)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    int          m_bht [NBHT];

    function automatic void model_reset();
        m_pc = 32'h0;
        foreach (m_bht[i]) m_bht[i] = 1;
    endfunction

    function automatic void model_predict(input logic [31:0] ins, input logic [31:0] pc,
                                          output bit est, output logic [31:0] tgt);
        logic [31:0] jimm, bimm;
        jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        est = 1'b0;
        tgt = pc + 32'd4;
        if (ins[6:0] == 7'h6F) begin
            est = 1'b1;
            tgt = pc + jimm;
        end else if (ins[6:0] == 7'h63) begin
            est = (m_bht[int'((pc >> 2) % NBHT)] >= 2);
            tgt = pc + bimm;
        end
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_edge();
        bit          est;
        logic [31:0] tgt;
        int          idx;
        if (reset) begin
            model_reset();
            return;
        end
        model_predict(imem_bus.imem_rdata, m_pc, est, tgt);
        idx = int'((ex_branch_pc >> 2) % NBHT);
        if (ex_branch_valid) begin
            if (ex_branch_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else                 m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (ex_mispredict)  m_pc = ex_redirect_pc & 32'hFFFF_FFFC;
        else if (stall)     m_pc = m_pc;
        else if (est)       m_pc = tgt;
        else                m_pc = m_pc + 32'd4;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [31:0] ins, input logic st, input logic mis,
                         input logic [31:0] rpc, input logic bv, input logic [31:0] bpc,
                         input logic bt);
        imem_bus.imem_rdata = ins;
        stall               = st;
        ex_mispredict       = mis;
        ex_redirect_pc      = rpc;
        ex_branch_valid     = bv;
        ex_branch_pc        = bpc;
        ex_branch_taken     = bt;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #30;
        reset = 1'b0;
        #1;
        n_cmp++; if (IF_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want %h", IF_pc, 32'h0); end
        n_cmp++; if (IF_pc_plus_4 !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h want %h", IF_pc_plus_4, 32'h4); end
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL rst_est: got %b want 0", IF_branch_estimation); end
        n_cmp++; if (IF_instruction !== ADDI) begin n_fail++; $display("FAIL rst_instr: got %h want %h", IF_instruction, ADDI); end
        n_cmp++; if (imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want %h", imem_bus.imem_addr, 32'h0); end
    endtask

    task automatic test_sequential();
        tick(); #1;
        n_cmp++; if (IF_pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc4: got %h want %h", IF_pc, 32'h4); end
        tick(); #1;
        n_cmp++; if (IF_pc !== 32'h8) begin n_fail++; $display("FAIL seq_pc8: got %h want %h", IF_pc, 32'h8); end
        drive(ADDI, 1, 0, 0, 0, 0, 0);
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h8) begin n_fail++; $display("FAIL seq_stall_hold: got %h want %h", IF_pc, 32'h8); end
        tick(); #1;
        n_cmp++; if (IF_pc !== 32'hC) begin n_fail++; $display("FAIL seq_after_stall: got %h want %h", IF_pc, 32'hC); end
    endtask

    task automatic test_mid_reset();
        repeat (13) tick();
        #1;
        n_cmp++; if (IF_pc !== 32'h40) begin n_fail++; $display("FAIL mrst_pre: got %h want %h", IF_pc, 32'h40); end
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (IF_pc !== 32'h0) begin n_fail++; $display("FAIL mrst_async: got %h want %h", IF_pc, 32'h0); end
        // Control inputs during reset must be ignored, including BHT updates.
        drive(ADDI, 0, 1, 32'h100, 1, 32'h0, 1);
        tick();
        tick();
        #1;
        n_cmp++; if (IF_pc !== 32'h0) begin n_fail++; $display("FAIL mrst_hold: got %h want %h", IF_pc, 32'h0); end
        reset = 1'b0;
        drive(BEQ8, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL mrst_bht: got %b want 0", IF_branch_estimation); end
        tick(); #1;
        n_cmp++; if (IF_pc !== 32'h4) begin n_fail++; $display("FAIL mrst_beq_nt: got %h want %h", IF_pc, 32'h4); end
    endtask

    task automatic test_jal();
        drive(ADDI, 0, 1, 32'h10, 0, 0, 0);
        tick();
        drive(JAL16, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h10) begin n_fail++; $display("FAIL jal_pc: got %h want %h", IF_pc, 32'h10); end
        n_cmp++; if (IF_branch_estimation !== 1'b1) begin n_fail++; $display("FAIL jal_est: got %b want 1", IF_branch_estimation); end
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h20) begin n_fail++; $display("FAIL jal_target: got %h want %h", IF_pc, 32'h20); end
    endtask

    task automatic test_bht_training();
        reset = 1'b1;
        model_reset();
        #1;
        reset = 1'b0;
        drive(BEQ8, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL bht_init_est: got %b want 0", IF_branch_estimation); end
        tick();
        drive(ADDI, 0, 0, 0, 1, 32'h0, 1);
        #1;
        n_cmp++; if (IF_pc !== 32'h4) begin n_fail++; $display("FAIL bht_init_next: got %h want %h", IF_pc, 32'h4); end
        tick();
        tick();
        drive(ADDI, 0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(BEQ8, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b1) begin n_fail++; $display("FAIL bht_trained_est: got %b want 1", IF_branch_estimation); end
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h8) begin n_fail++; $display("FAIL bht_trained_next: got %h want %h", IF_pc, 32'h8); end
        // Four not-taken updates bring the counter from 11 down to 00.
        drive(ADDI, 0, 0, 0, 1, 32'h0, 0);
        repeat (4) tick();
        drive(ADDI, 0, 1, 32'h0, 0, 0, 0);
        tick();
        drive(BEQ8, 0, 1, 32'h0, 1, 32'h0, 0);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL bht_snt_est: got %b want 0", IF_branch_estimation); end
        tick();
        // An extra not-taken must leave 00 in place, so one taken gives 01.
        drive(BEQ8, 0, 1, 32'h0, 1, 32'h0, 1);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL bht_sat_low: got %b want 0", IF_branch_estimation); end
        tick();
        #1;
        // Counter is 01 and a taken update to the same entry is in flight.
        n_cmp++; if (IF_branch_estimation !== 1'b0) begin n_fail++; $display("FAIL bht_same_cycle: got %b want 0", IF_branch_estimation); end
        tick();
        drive(BEQ8, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_branch_estimation !== 1'b1) begin n_fail++; $display("FAIL bht_post_update: got %b want 1", IF_branch_estimation); end
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h8) begin n_fail++; $display("FAIL bht_post_next: got %h want %h", IF_pc, 32'h8); end
    endtask

    task automatic test_priority();
        drive(JAL16, 1, 1, 32'h1236, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h8) begin n_fail++; $display("FAIL prio_cur_pc: got %h want %h", IF_pc, 32'h8); end
        n_cmp++; if (IF_branch_estimation !== 1'b1) begin n_fail++; $display("FAIL prio_est: got %b want 1", IF_branch_estimation); end
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'h1234) begin n_fail++; $display("FAIL prio_next: got %h want %h", IF_pc, 32'h1234); end
    endtask

    task automatic test_wrap();
        drive(ADDI, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        tick();
        drive(ADDI, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (IF_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", IF_pc, 32'hFFFF_FFFC); end
        n_cmp++; if (IF_pc_plus_4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want %h", IF_pc_plus_4, 32'h0); end
        tick();
        #1;
        n_cmp++; if (IF_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want %h", IF_pc, 32'h0); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        bit          est;
        logic [31:0] tgt;
        for (int n = 0; n < 400; n++) begin
            reset = 1'b0;
            ins = $urandom;
            case ($urandom_range(0, 3))
                0: ins[6:0] = 7'b0010011;
                1: ins[6:0] = 7'h6F;
                2: ins[6:0] = 7'h63;
                default: ins[6:0] = 7'h67;
            endcase
            drive(ins, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), $urandom,
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                model_reset();
            end
            #1;
            model_predict(ins, m_pc, est, tgt);
            n_cmp++; if (IF_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, IF_pc, m_pc); end
            n_cmp++; if (IF_pc_plus_4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc4[%0d]: got %h want %h", n, IF_pc_plus_4, m_pc + 32'd4); end
            n_cmp++; if (IF_branch_estimation !== est) begin n_fail++; $display("FAIL rnd_est[%0d]: got %b want %b", n, IF_branch_estimation, est); end
            n_cmp++; if (IF_instruction !== ins) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h want %h", n, IF_instruction, ins); end
            n_cmp++; if (imem_bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", n, imem_bus.imem_addr, m_pc); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mid_reset();
        test_jal();
        test_bht_training();
        test_priority();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
